bsg_channel_widen: RTL

Narrow-to-wide channel assembler, the receive-side counterpart of bsg_channel_narrow. It collects ceil(width_out_p/width_in_p) consecutive narrow beats into one wide word. It presents that word with a valid/yumi handshake. It sits at the far end of a narrowed link and restores the original word, using the same slice ordering as the narrowing side.

---
 rtl/bsg_channel_widen.sv | 108 ++++++++++
 1 files changed

// File: rtl/bsg_channel_widen.sv
// Narrow-to-wide channel assembler: gathers ceil(width_out_p/width_in_p) narrow
// beats into one wide word and presents it with a valid/yumi handshake.
module bsg_channel_widen #(
   parameter int width_in_p   = 2,
   parameter int width_out_p  = 3,
   parameter bit lsb_to_msb_p = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   v_i,
   input  logic [width_in_p-1:0]  data_i,
   output logic                   ready_o,
   output logic                   v_o,
   output logic [width_out_p-1:0] data_o,
   input  logic                   yumi_i
);

   localparam int divisions_raw_lp = (width_out_p + width_in_p - 1) / width_in_p;
   localparam int divisions_lp     = (divisions_raw_lp < 1) ? 1 : divisions_raw_lp;
   localparam int count_w_lp       = (divisions_lp > 1) ? $clog2(divisions_lp) : 1;
   localparam int asm_w_lp         = divisions_lp * width_in_p;
   localparam logic [count_w_lp-1:0] last_count_lp = count_w_lp'(divisions_lp - 1);
   localparam int first_base_lp    = lsb_to_msb_p ? 0 : (divisions_lp - 1) * width_in_p;

   // Handshake contract: a beat moves when v_i & ready_o; a word moves when
   // yumi_i, which the consumer raises only while v_o is high. ready_o looks
   // at yumi_i combinationally so a freed word slot can take a beat at once.
   typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_e;

   state_e                  state_q, state_d;
   logic [count_w_lp-1:0]   count_q, count_d;
   logic [asm_w_lp-1:0]     asm_q,   asm_d;
   logic [count_w_lp-1:0]   slot;
   int                      slot_base;
   logic                    accept;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= FILL;
         count_q <= '0;
         asm_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         asm_q   <= asm_d;
      end
   end

   // In FULL count_q is always 0, so the same slot mapping serves the refill beat.
   always_comb begin
      slot      = lsb_to_msb_p ? count_q : (last_count_lp - count_q);
      slot_base = int'(slot) * width_in_p;
      accept    = v_i & ready_o;
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      asm_d   = asm_q;
      case (state_q)
         FILL: begin
            if (accept) begin
               asm_d[slot_base +: width_in_p] = data_i;
               if (count_q == last_count_lp) begin
                  count_d = '0;
                  state_d = FULL;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         FULL: begin
            if (yumi_i) begin
               if (accept) begin
                  asm_d[first_base_lp +: width_in_p] = data_i;
                  if (divisions_lp == 1) begin
                     state_d = FULL;
                     count_d = '0;
                  end else begin
                     state_d = FILL;
                     count_d = count_w_lp'(1);
                  end
               end else begin
                  state_d = FILL;
               end
            end
         end
      endcase
   end

   always_comb begin
      v_o     = (state_q == FULL);
      ready_o = (state_q == FILL) | yumi_i;
      data_o  = asm_q[width_out_p-1:0];
   end

   // Pad bits above width_out_p exist only to keep every slice full width.
   generate
      if (asm_w_lp > width_out_p) begin : g_pad
         logic unused_pad;
         assign unused_pad = ^asm_q[asm_w_lp-1:width_out_p];
      end
   endgenerate

   yumi_without_valid_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      yumi_i |-> v_o);

endmodule
